// File: rtl/pwm_fade_scheduler.sv
// Per-channel fade engine: on every prescaled tick, each current level steps toward its target, and changed levels are written out.
// Optional feature macro FADE_SNAP_EN adds a per-channel snap bit that lets a channel jump straight to its target.
module pwm_fade_scheduler #(
  parameter int CHANNELS    = 8,
  parameter int INDEX_WIDTH = 3,
  parameter int PRESCALE    = 24000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   target_we,
  input  logic [INDEX_WIDTH-1:0] target_index,
  input  logic [15:0]            target_value,
`ifdef FADE_SNAP_EN
  input  logic                   target_snap,
`endif
  input  logic [15:0]            step,
  output logic                   value_we,
  output logic [INDEX_WIDTH-1:0] value_index,
  output logic [15:0]            value_data,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   overrun
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOAD, S_CALC, S_WRITE} state_e;

  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic                   overrun_q, overrun_d;
  logic [15:0]            next_q, next_d;
  logic                   we_q, we_d;
  logic [INDEX_WIDTH-1:0] vidx_q, vidx_d;
  logic [15:0]            vdata_q, vdata_d;
  logic                   done_q, done_d;
  logic                   busy_q, busy_d;

  logic [15:0] target_mem  [CHANNELS];
  logic [15:0] current_mem [CHANNELS];
  logic [15:0] rd_tgt_q, rd_cur_q;
  logic [15:0] calc_next;
  logic [16:0] diff_up, diff_dn;
  logic        tick, last_idx, host_we, snap_hit;

  assign tick     = (cnt_q == CW'(PRESCALE - 1));
  assign last_idx = (idx_q == INDEX_WIDTH'(CHANNELS - 1));
  assign host_we  = target_we && (state_q != S_CLEAR) &&
                    ({1'b0, target_index} < (INDEX_WIDTH + 1)'(CHANNELS));

  // Level and target tables with a registered read; a host write in the read cycle lands after the old value is captured.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (host_we) target_mem[target_index] <= target_value;
      else if (state_q == S_CLEAR) target_mem[idx_q] <= '0;
      if (state_q == S_CLEAR) current_mem[idx_q] <= '0;
      else if (state_q == S_WRITE) current_mem[idx_q] <= next_q;
    end
    if (state_q == S_LOAD) begin
      rd_tgt_q <= target_mem[idx_q];
      rd_cur_q <= current_mem[idx_q];
    end
  end

`ifdef FADE_SNAP_EN
  logic snap_mem [CHANNELS];
  logic rd_snap_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == S_CLEAR || state_q == S_WRITE) snap_mem[idx_q] <= 1'b0;
      if (host_we) snap_mem[target_index] <= target_snap;
    end
    if (state_q == S_LOAD) rd_snap_q <= snap_mem[idx_q];
  end

  assign snap_hit = rd_snap_q;
`else
  assign snap_hit = 1'b0;
`endif

  // Differences are taken at 17 bits so the step limit can never overshoot or wrap.
  always_comb begin
    diff_up   = {1'b0, rd_tgt_q} - {1'b0, rd_cur_q};
    diff_dn   = {1'b0, rd_cur_q} - {1'b0, rd_tgt_q};
    calc_next = rd_tgt_q;
    if (step != '0 && rd_tgt_q != rd_cur_q && !snap_hit) begin
      if (rd_tgt_q > rd_cur_q) begin
        if (diff_up > {1'b0, step}) calc_next = rd_cur_q + step;
      end else if (diff_dn > {1'b0, step}) begin
        calc_next = rd_cur_q - step;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    next_d    = next_q;
    we_d      = 1'b0;
    vidx_d    = vidx_q;
    vdata_d   = vdata_q;
    done_d    = 1'b0;
    busy_d    = (state_q != S_IDLE);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;

    // Only one tick can be queued; a second one while queued is dropped and flagged.
    if (tick && state_q != S_IDLE) begin
      if (pending_q) overrun_d = 1'b1;
      else           pending_d = 1'b1;
    end

    case (state_q)
      S_CLEAR: begin
        we_d    = 1'b1;
        vidx_d  = idx_q;
        vdata_d = '0;
        if (last_idx) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (tick || pending_q) begin
          state_d   = S_LOAD;
          idx_d     = '0;
          pending_d = 1'b0;
        end
      end
      S_LOAD: state_d = S_CALC;
      S_CALC: begin
        next_d  = calc_next;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        we_d    = (next_q != rd_cur_q);
        vidx_d  = idx_q;
        vdata_d = next_q;
        if (last_idx) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      idx_q     <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      next_q    <= '0;
      we_q      <= 1'b0;
      vidx_q    <= '0;
      vdata_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      next_q    <= next_d;
      we_q      <= we_d;
      vidx_q    <= vidx_d;
      vdata_q   <= vdata_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign value_we    = we_q;
  assign value_index = vidx_q;
  assign value_data  = vdata_q;
  assign busy        = busy_q;
  assign sweep_done  = done_q;
  assign overrun     = overrun_q;
endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// Testbench for pwm_fade_scheduler: two instances (a slow tick and a fast, overrunning tick) are compared every cycle against a timeline model.
// Directed vectors pin the observed write sequences to hand-computed values.
module tb_pwm_fade_scheduler;
  localparam int NCH = 8;
  localparam int PA  = 40;
  localparam int PB  = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        target_we = 1'b0;
  logic [2:0]  target_index = '0;
  logic [15:0] target_value = '0;
  logic [15:0] step = '0;
`ifdef FADE_SNAP_EN
  logic        target_snap = 1'b0;
`endif

  logic        weA, busyA, doneA, ovrA;
  logic [2:0]  idxA;
  logic [15:0] dataA;
  logic        weB, busyB, doneB, ovrB;
  logic [2:0]  idxB;
  logic [15:0] dataB;

  int testsRun = 0;
  int testsFailed = 0;

  pwm_fade_scheduler #(.CHANNELS(NCH), .INDEX_WIDTH(3), .PRESCALE(PA)) dutA (
    .clock(clock), .reset(reset), .target_we(target_we), .target_index(target_index),
    .target_value(target_value),
`ifdef FADE_SNAP_EN
    .target_snap(target_snap),
`endif
    .step(step), .value_we(weA), .value_index(idxA), .value_data(dataA),
    .busy(busyA), .sweep_done(doneA), .overrun(ovrA)
  );

  pwm_fade_scheduler #(.CHANNELS(NCH), .INDEX_WIDTH(3), .PRESCALE(PB)) dutB (
    .clock(clock), .reset(reset), .target_we(target_we), .target_index(target_index),
    .target_value(target_value),
`ifdef FADE_SNAP_EN
    .target_snap(target_snap),
`endif
    .step(step), .value_we(weB), .value_index(idxB), .value_data(dataB),
    .busy(busyB), .sweep_done(doneB), .overrun(ovrB)
  );

  always #5 clock = ~clock;

  // Model state: per instance, cycles since reset, sweep start time, and the level tables.
  bit modelValid = 1'b0;
  int cyc [2];
  int swS [2];
  bit swOn [2];
  bit pend [2];
  int ovr [2];
  int tgtM [2][NCH];
  int curM [2][NCH];
  int rdT [2];
  int rdC [2];
  int nxt [2];
  int eWe [2];
  int eIdx [2];
  int eData [2];
  int eDone [2];
  int eBusy [2];

  int wrIdx[$];
  int wrData[$];
  int doneCnt = 0;
  int expI[$];
  int expD[$];

  task automatic checkOutput(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int fade(input int t, input int c, input int s);
    if (s == 0 || t == c) return t;
    if (t > c) return (t - c <= s) ? t : c + s;
    return (c - t <= s) ? t : c - s;
  endfunction

  // Channel i of a sweep starting at edge S is read at S+1+3i, computed at S+2+3i, written at S+3+3i.
  task automatic modelEdge(input int u, input int p);
    bit tick, clearing, inSweep;
    int rel, ch, ph;
    if (reset) begin
      cyc[u] = 0; pend[u] = 0; ovr[u] = 0; swOn[u] = 0;
      eWe[u] = 0; eIdx[u] = 0; eData[u] = 0; eDone[u] = 0; eBusy[u] = 1;
      modelValid = 1'b1;
      return;
    end
    cyc[u]++;
    tick     = (cyc[u] % p == 0);
    clearing = (cyc[u] <= NCH);
    inSweep  = swOn[u] && cyc[u] > swS[u] && cyc[u] <= swS[u] + 3 * NCH;
    eWe[u]   = 0;
    eDone[u] = 0;
    eBusy[u] = (clearing || inSweep) ? 1 : 0;
    if (clearing) begin
      tgtM[u][cyc[u]-1] = 0;
      curM[u][cyc[u]-1] = 0;
      eWe[u] = 1; eIdx[u] = cyc[u] - 1; eData[u] = 0;
    end else if (inSweep) begin
      rel = cyc[u] - swS[u] - 1;
      ch  = rel / 3;
      ph  = rel % 3;
      if (ph == 0) begin
        rdT[u] = tgtM[u][ch];
        rdC[u] = curM[u][ch];
      end else if (ph == 1) begin
        nxt[u] = fade(rdT[u], rdC[u], int'(step));
      end else begin
        curM[u][ch] = nxt[u];
        eWe[u]   = (nxt[u] != rdC[u]) ? 1 : 0;
        eIdx[u]  = ch;
        eData[u] = nxt[u];
        eDone[u] = (ch == NCH - 1) ? 1 : 0;
      end
    end else if (tick || pend[u]) begin
      swOn[u] = 1; swS[u] = cyc[u]; pend[u] = 0;
    end
    if ((clearing || inSweep) && tick) begin
      if (pend[u]) ovr[u] = 1;
      else pend[u] = 1;
    end
    if (!clearing && target_we && int'(target_index) < NCH)
      tgtM[u][target_index] = int'(target_value);
  endtask

  always @(posedge clock) begin
    modelEdge(0, PA);
    modelEdge(1, PB);
  end

  always @(negedge clock) begin
    if (modelValid) begin
      checkOutput("weA", int'(weA), eWe[0]);
      checkOutput("doneA", int'(doneA), eDone[0]);
      checkOutput("busyA", int'(busyA), eBusy[0]);
      checkOutput("ovrA", int'(ovrA), ovr[0]);
      if (eWe[0] != 0) begin
        checkOutput("idxA", int'(idxA), eIdx[0]);
        checkOutput("dataA", int'(dataA), eData[0]);
      end
      checkOutput("weB", int'(weB), eWe[1]);
      checkOutput("doneB", int'(doneB), eDone[1]);
      checkOutput("busyB", int'(busyB), eBusy[1]);
      checkOutput("ovrB", int'(ovrB), ovr[1]);
      if (eWe[1] != 0) begin
        checkOutput("idxB", int'(idxB), eIdx[1]);
        checkOutput("dataB", int'(dataB), eData[1]);
      end
    end
  end

  always @(negedge clock) begin
    if (modelValid) begin
      if (weA) begin
        wrIdx.push_back(int'(idxA));
        wrData.push_back(int'(dataA));
      end
      if (doneA) doneCnt++;
    end
  end

  task automatic applyStimulus(input int ch, input int val);
    target_index = ch[2:0];
    target_value = val[15:0];
    target_we    = 1'b1;
    @(negedge clock);
    target_we    = 1'b0;
  endtask

  task automatic waitCyc(input int n);
    int k;
    k = 0;
    while (cyc[0] != n && k < 5000) begin
      @(negedge clock);
      k++;
    end
    if (cyc[0] != n) checkOutput("wait_cycle", cyc[0], n);
  endtask

  task automatic resetLog();
    wrIdx.delete();
    wrData.delete();
    doneCnt = 0;
    expI.delete();
    expD.delete();
  endtask

  task automatic addExp(input int i, input int d);
    expI.push_back(i);
    expD.push_back(d);
  endtask

  task automatic checkLog(input string tag, input int expDone);
    checkOutput({tag, "_len"}, wrIdx.size(), expI.size());
    for (int i = 0; i < expI.size(); i++) begin
      if (i < wrIdx.size()) begin
        checkOutput($sformatf("%s_idx%0d", tag, i), wrIdx[i], expI[i]);
        checkOutput($sformatf("%s_data%0d", tag, i), wrData[i], expD[i]);
      end
    end
    checkOutput({tag, "_done"}, doneCnt, expDone);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clock);
    reset = 1'b0;
    checkOutput("rst_we", int'(weA), 0);
    checkOutput("rst_busy", int'(busyA), 1);
    checkOutput("rst_ovr", int'(ovrA), 0);
    checkOutput("rst_idx", int'(idxA), 0);
    checkOutput("rst_data", int'(dataA), 0);

    waitCyc(8);
    checkOutput("t1_busy_last", int'(busyA), 1);
    checkOutput("t1_idx_last", int'(idxA), 7);
    waitCyc(9);
    checkOutput("t1_busy_end", int'(busyA), 0);
    checkOutput("t1_we_end", int'(weA), 0);
    waitCyc(12);
    expI.delete(); expD.delete();
    for (int i = 0; i < NCH; i++) addExp(i, 0);
    checkLog("t1", 0);

    resetLog();
    step = 16'h1000;
    applyStimulus(2, 32'h3800);
    waitCyc(235);
    addExp(2, 32'h1000); addExp(2, 32'h2000); addExp(2, 32'h3000); addExp(2, 32'h3800);
    checkLog("t2", 5);
    checkOutput("t2_model_cur2", curM[0][2], 32'h3800);

    resetLog();
    applyStimulus(2, 0);
    waitCyc(395);
    step = 16'h0000;
    applyStimulus(2, 32'hF000);
    waitCyc(435);
    step = 16'h2000;
    applyStimulus(2, 32'hFFFF);
    waitCyc(515);
    addExp(2, 32'h2800); addExp(2, 32'h1800); addExp(2, 32'h0800); addExp(2, 32'h0000);
    addExp(2, 32'hF000); addExp(2, 32'hFFFF);
    checkLog("t3", 7);
    checkOutput("t3_model_cur2", curM[0][2], 32'hFFFF);

    resetLog();
    step = 16'h0000;
    applyStimulus(7, 32'hFFFF);
    // Lands on the read cycle of channel 5 in the sweep starting at 560.
    waitCyc(575);
    applyStimulus(5, 32'h4242);
    waitCyc(590);
    addExp(7, 32'hFFFF);
    checkLog("t4a", 2);
    waitCyc(630);
    addExp(5, 32'h4242);
    checkLog("t4b", 3);

    applyStimulus(4, 32'h1234);
    waitCyc(654);
    checkOutput("t5_ovrB", int'(ovrB), 1);
    checkOutput("t5_ovrA", int'(ovrA), 0);
    resetLog();
    // Reset is sampled on the write edge of channel 4 in the sweep starting at 640.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("t6_rst_we", int'(weA), 0);
    checkOutput("t6_rst_busy", int'(busyA), 1);
    checkOutput("t6_rst_ovrB", int'(ovrB), 0);
    waitCyc(2);
    applyStimulus(3, 32'h5555);
    waitCyc(70);
    for (int i = 0; i < NCH; i++) addExp(i, 0);
    checkLog("t6", 1);
    checkOutput("t6_ovrA", int'(ovrA), 0);
    checkOutput("t6_ovrB", int'(ovrB), 1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
